key_stream_assembler: RTL and testbench
=======================================

// Module: key_stream_assembler
// PURPOSE
//  Parametrised successor to the fixed-ratio key assembler. Collects KEY_SIZE-bit key chunks
//  over a valid/ready handshake into one MSG_SIZE-bit key word for the XOR cipher datapath.
//  Supports MSG_SIZE not a multiple of KEY_SIZE, a REPEAT (tiling) mode, output backpressure
//  and a synchronous clear. Sits between the key input pins and the XOR stage.
// PARAMETERS
//  KEY_SIZE   4   width of one key chunk, >=1
//  MSG_SIZE   8   width of the assembled key word, >=KEY_SIZE
//  derived: NUM_CHUNKS = ceil(MSG_SIZE/KEY_SIZE); ACC_W = NUM_CHUNKS*KEY_SIZE; CNT_W = $clog2(NUM_CHUNKS+1)
// PORTS
//  iClk            in   1           clock, rising edge
//  iRst            in   1           asynchronous reset, active-low
//  iClear          in   1           synchronous clear of assembly state
//  iEn             in   1           enables chunk acceptance
//  iMode           in   1           0 = SHIFT (NUM_CHUNKS chunks), 1 = REPEAT (one chunk tiled)
//  iKey            in   KEY_SIZE    key chunk
//  iKey_Valid      in   1           iKey valid this cycle
//  oKey_Ready      out  1           block can accept a chunk this cycle
//  oKey_Assembled  out  MSG_SIZE    assembled key word
//  oAssembled      out  1           oKey_Assembled valid; held until iOut_Ready
//  iOut_Ready      in   1           downstream consumes the word
//  oChunk_Count    out  CNT_W       chunks accepted into the current word
// BEHAVIOUR
//  - Reset (iRst=0, async): state FILL, acc=0, oKey_Assembled=0, oAssembled=0, oChunk_Count=0,
//    mode latch=0. oKey_Ready is combinational and follows the reset state (1 when iEn=1).
//  - States: FILL (collecting chunks), HOLD (word presented).
//  - oKey_Ready = (state==FILL) && iEn. Accept = iKey_Valid && oKey_Ready.
//  - Mode latch: iMode is sampled on the first accept of a word (oChunk_Count==0).
//    iMode changes mid-word are ignored.
//  - SHIFT accept: acc <= {acc[ACC_W-KEY_SIZE-1:0], iKey}; count++. The first chunk ends up
//    most significant.
//  - SHIFT completion (the accept that brings count to NUM_CHUNKS):
//    oKey_Assembled <= acc_next[ACC_W-1 -: MSG_SIZE]; low (ACC_W-MSG_SIZE) bits of the last
//    chunk are discarded. Also oAssembled <= 1 and state <= HOLD, all on the same edge.
//  - REPEAT accept: one chunk completes the word.
//    oKey_Assembled <= {NUM_CHUNKS{iKey}}[ACC_W-1 -: MSG_SIZE]; oChunk_Count <= 1; HOLD.
//  - Latency: oAssembled is high the cycle after the completing accept.
//  - HOLD: oKey_Ready=0. oKey_Assembled is stable while oAssembled=1.
//    On iOut_Ready=1: state <= FILL, oAssembled <= 0, oKey_Assembled <= 0, acc <= 0, count <= 0.
//    A new chunk can be accepted the cycle after the handoff; there is no same-cycle accept.
//  - iOut_Ready while in FILL: ignored.
//  - iEn=0: blocks acceptance only. A HOLD-to-FILL handoff still occurs.
//  - iClear=1 (sync): all state returns to its reset values on the next edge. iClear overrides
//    a simultaneous accept and a simultaneous handoff.
//  - Async reset mid-word or in HOLD: partial word discarded, no output pulse.
//  - count never exceeds NUM_CHUNKS. No wrap-around is possible because acceptance stops in HOLD.
// TESTING
//  1. Defaults, SHIFT: accept 4'hA, then 4'h5 -> oAssembled=1 the next cycle,
//     oKey_Assembled=8'hA5, oChunk_Count=2.
//  2. Backpressure: hold iOut_Ready=0 for 5 cycles -> 8'hA5 stable, oKey_Ready=0,
//     iKey_Valid ignored. iOut_Ready=1 -> next cycle oAssembled=0, oKey_Assembled=0, oKey_Ready=1.
//  3. REPEAT: iMode=1, accept 4'h3 -> next cycle oKey_Assembled=8'h33, oChunk_Count=1.
//     iMode toggled after the first SHIFT chunk -> word still assembled in SHIFT.
//  4. KEY_SIZE=3, MSG_SIZE=8: chunks 3'b101, 3'b011, 3'b110 -> oKey_Assembled=8'hAF
//     (acc 9'b101011110, LSB dropped). REPEAT with 3'b110 -> 8'hDB.
//  5. Stalls: iEn=0 with iKey_Valid=1 -> no accept, count unchanged. iKey_Valid gaps between
//     chunks -> same word as scenario 1.
//  6. Clear/reset: iClear after one chunk -> count=0, then a fresh word assembles correctly.
//     iRst pulsed while in HOLD -> all outputs 0 immediately (async), state FILL.

Source files
------------

// File: rtl/key_stream_assembler.sv
// key_stream_assembler: gathers KEY_SIZE chunks into one MSG_SIZE key word
// for the XOR cipher datapath, with SHIFT/REPEAT modes and output backpressure.
module key_stream_assembler #(
  parameter int KEY_SIZE = 4,
  parameter int MSG_SIZE = 8,
  localparam int NUM_CHUNKS = (MSG_SIZE + KEY_SIZE - 1) / KEY_SIZE,
  localparam int ACC_W = NUM_CHUNKS * KEY_SIZE,
  localparam int CNT_W = $clog2(NUM_CHUNKS + 1)
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iClear,
  input  logic                iEn,
  input  logic                iMode,
  input  logic [KEY_SIZE-1:0] iKey,
  input  logic                iKey_Valid,
  output logic                oKey_Ready,
  output logic [MSG_SIZE-1:0] oKey_Assembled,
  output logic                oAssembled,
  input  logic                iOut_Ready,
  output logic [CNT_W-1:0]    oChunk_Count
);

  // Partial-word storage holds every chunk but the last; the last
  // chunk is folded in directly from iKey on the completing edge.
  localparam int PART_W =
    (NUM_CHUNKS > 1) ? (NUM_CHUNKS - 1) * KEY_SIZE : 1;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t              r_state;
  logic [PART_W-1:0]   r_acc;
  logic [MSG_SIZE-1:0] r_key;
  logic                r_assembled;
  logic [CNT_W-1:0]    r_count;
  logic                r_mode;

  logic [ACC_W-1:0]    w_acc_next;
  logic [ACC_W-1:0]    w_tile;
  logic                w_accept;
  logic                w_last;
  logic                w_mode;

  if (NUM_CHUNKS > 1) begin : g_multi
    assign w_acc_next = {r_acc, iKey};
  end else begin : g_single
    assign w_acc_next = iKey;
  end

  assign w_tile     = {NUM_CHUNKS{iKey}};
  assign oKey_Ready = (r_state == FILL) && iEn;
  assign w_accept   = iKey_Valid && oKey_Ready;
  assign w_last     = (r_count == CNT_W'(NUM_CHUNKS - 1));
  // Mode is taken live on the first chunk, then from the latch.
  assign w_mode     = (r_count == '0) ? iMode : r_mode;

  assign oKey_Assembled = r_key;
  assign oAssembled     = r_assembled;
  assign oChunk_Count   = r_count;

  // Fill/hold state machine with registered word, flag and count.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_state     <= FILL;
      r_acc       <= '0;
      r_key       <= '0;
      r_assembled <= 1'b0;
      r_count     <= '0;
      r_mode      <= 1'b0;
    end else if (iClear) begin
      r_state     <= FILL;
      r_acc       <= '0;
      r_key       <= '0;
      r_assembled <= 1'b0;
      r_count     <= '0;
      r_mode      <= 1'b0;
    end else begin
      unique case (r_state)
        FILL: begin
          if (w_accept) begin
            if (r_count == '0) begin
              r_mode <= iMode;
            end
            if (w_mode) begin
              r_key       <= w_tile[ACC_W-1 -: MSG_SIZE];
              r_count     <= CNT_W'(1);
              r_assembled <= 1'b1;
              r_state     <= HOLD;
            end else if (w_last) begin
              r_key       <= w_acc_next[ACC_W-1 -: MSG_SIZE];
              r_count     <= r_count + CNT_W'(1);
              r_assembled <= 1'b1;
              r_state     <= HOLD;
            end else begin
              r_acc   <= w_acc_next[PART_W-1:0];
              r_count <= r_count + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (iOut_Ready) begin
            r_state     <= FILL;
            r_assembled <= 1'b0;
            r_key       <= '0;
            r_acc       <= '0;
            r_count     <= '0;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_key_stream_assembler.sv
// tb_key_stream_assembler: randomized and directed checks of the key
// assembler against a queue-free arithmetic reference model.
module tb_key_stream_assembler;

  localparam int KS = 4;
  localparam int MS = 8;
  localparam int NC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0, en = 1'b0, mode = 1'b0, kv = 1'b0, ordy = 1'b0;
  logic [KS-1:0] key = '0;
  logic rdy, asm_o;
  logic [MS-1:0] word;
  logic [1:0] cnt;

  logic b_clr = 1'b0, b_en = 1'b0, b_mode = 1'b0;
  logic b_kv = 1'b0, b_ordy = 1'b0;
  logic [2:0] b_key = '0;
  logic b_rdy, b_asm;
  logic [7:0] b_word;
  logic [1:0] b_cnt;

  int checks = 0;
  int errors = 0;

  int m_n;
  bit m_hold;
  bit m_mode;
  longint unsigned m_acc;
  longint unsigned m_word;

  always #5 clk = ~clk;

  key_stream_assembler #(.KEY_SIZE(KS), .MSG_SIZE(MS)) u_dut (
    .iClk(clk), .iRst(rst_n), .iClear(clr), .iEn(en),
    .iMode(mode), .iKey(key), .iKey_Valid(kv),
    .oKey_Ready(rdy), .oKey_Assembled(word),
    .oAssembled(asm_o), .iOut_Ready(ordy),
    .oChunk_Count(cnt)
  );

  key_stream_assembler #(.KEY_SIZE(3), .MSG_SIZE(8)) u_dut3 (
    .iClk(clk), .iRst(rst_n), .iClear(b_clr), .iEn(b_en),
    .iMode(b_mode), .iKey(b_key), .iKey_Valid(b_kv),
    .oKey_Ready(b_rdy), .oKey_Assembled(b_word),
    .oAssembled(b_asm), .iOut_Ready(b_ordy),
    .oChunk_Count(b_cnt)
  );

  function automatic void model_reset();
    m_n = 0; m_hold = 0; m_mode = 0;
    m_acc = 0; m_word = 0;
  endfunction

  function automatic longint unsigned tile(longint unsigned k);
    longint unsigned t = 0;
    for (int i = 0; i < NC; i++) t = (t << KS) | k;
    return t >> (NC * KS - MS);
  endfunction

  function automatic void model_update();
    if (!rst_n || clr) begin
      model_reset();
    end else if (m_hold) begin
      if (ordy) begin
        m_hold = 0; m_word = 0; m_n = 0; m_acc = 0;
      end
    end else if (en && kv) begin
      if (m_n == 0) m_mode = mode;
      if (m_mode) begin
        m_word = tile(longint'(key));
        m_n = 1;
        m_hold = 1;
      end else begin
        m_acc = (m_acc << KS) | longint'(key);
        m_n++;
        if (m_n == NC) begin
          m_word = m_acc >> (NC * KS - MS);
          m_hold = 1;
        end
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic handoff();
    kv = 1'b0; ordy = 1'b1;
    step();
    ordy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1;
    model_reset();
    #1;
    checks++;
    if (word !== 8'h00 || asm_o !== 1'b0 || cnt !== 2'd0) begin
      errors++;
      $display("FAIL reset_out: got %h/%b/%0d expected 00/0/0",
               word, asm_o, cnt);
    end
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_rdy: got %b expected 1", rdy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_shift_basic();
    en = 1'b1; mode = 1'b0; kv = 1'b1; key = 4'hA;
    step();
    checks++;
    if (cnt !== 2'd1 || asm_o !== 1'b0) begin
      errors++;
      $display("FAIL shift_mid: got cnt %0d asm %b expected 1 0",
               cnt, asm_o);
    end
    key = 4'h5;
    step();
    kv = 1'b0;
    checks++;
    if (word !== 8'hA5 || asm_o !== 1'b1 || cnt !== 2'd2) begin
      errors++;
      $display("FAIL shift_word: got %h/%b/%0d expected a5/1/2",
               word, asm_o, cnt);
    end
  endtask

  task automatic test_backpressure();
    ordy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      kv = 1'b1; key = KS'($urandom);
      #1;
      checks++;
      if (rdy !== 1'b0) begin
        errors++;
        $display("FAIL bp_rdy: got %b expected 0", rdy);
      end
      step();
      checks++;
      if (word !== 8'hA5 || asm_o !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold: got %h/%b expected a5/1",
                 word, asm_o);
      end
    end
    handoff();
    #1;
    checks++;
    if (word !== 8'h00 || asm_o !== 1'b0 || rdy !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got %h/%b/%b expected 00/0/1",
               word, asm_o, rdy);
    end
  endtask

  task automatic test_repeat();
    logic [KS-1:0] k1, k2;
    logic [MS-1:0] exp;
    mode = 1'b1; kv = 1'b1; key = 4'h3;
    step();
    kv = 1'b0; mode = 1'b0;
    checks++;
    if (word !== 8'h33 || cnt !== 2'd1 || asm_o !== 1'b1) begin
      errors++;
      $display("FAIL repeat_word: got %h/%0d/%b expected 33/1/1",
               word, cnt, asm_o);
    end
    handoff();
    k1 = KS'($urandom); k2 = KS'($urandom);
    mode = 1'b0; kv = 1'b1; key = k1;
    step();
    mode = 1'b1; key = k2;
    step();
    kv = 1'b0; mode = 1'b0;
    exp = {k1, k2};
    checks++;
    if (word !== exp || cnt !== 2'd2) begin
      errors++;
      $display("FAIL mode_latch: got %h/%0d expected %h/2",
               word, cnt, exp);
    end
    handoff();
  endtask

  task automatic test_odd_size();
    logic [2:0] ks3 [3];
    ks3[0] = 3'b101; ks3[1] = 3'b011; ks3[2] = 3'b110;
    b_en = 1'b1; b_kv = 1'b1; b_mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b_key = ks3[i];
      step();
    end
    b_kv = 1'b0;
    checks++;
    if (b_word !== 8'hAF || b_cnt !== 2'd3 || b_asm !== 1'b1) begin
      errors++;
      $display("FAIL odd_shift: got %h/%0d/%b expected af/3/1",
               b_word, b_cnt, b_asm);
    end
    b_ordy = 1'b1; step(); b_ordy = 1'b0;
    b_mode = 1'b1; b_kv = 1'b1; b_key = 3'b110;
    step();
    b_kv = 1'b0; b_mode = 1'b0;
    checks++;
    if (b_word !== 8'hDB || b_cnt !== 2'd1) begin
      errors++;
      $display("FAIL odd_repeat: got %h/%0d expected db/1",
               b_word, b_cnt);
    end
    b_ordy = 1'b1; step(); b_ordy = 1'b0;
    checks++;
    if (b_asm !== 1'b0 || b_word !== 8'h00) begin
      errors++;
      $display("FAIL odd_release: got %b/%h expected 0/00",
               b_asm, b_word);
    end
  endtask

  task automatic test_stalls();
    en = 1'b0; kv = 1'b1; key = 4'hA;
    #1;
    checks++;
    if (rdy !== 1'b0) begin
      errors++;
      $display("FAIL stall_rdy: got %b expected 0", rdy);
    end
    repeat (3) step();
    checks++;
    if (cnt !== 2'd0 || asm_o !== 1'b0) begin
      errors++;
      $display("FAIL stall_en: got %0d/%b expected 0/0", cnt, asm_o);
    end
    en = 1'b1;
    step();
    kv = 1'b0;
    repeat (2) step();
    kv = 1'b1; key = 4'h5;
    step();
    kv = 1'b0;
    checks++;
    if (word !== 8'hA5 || asm_o !== 1'b1) begin
      errors++;
      $display("FAIL stall_gap: got %h/%b expected a5/1", word, asm_o);
    end
    en = 1'b0;
    handoff();
    en = 1'b1;
    checks++;
    if (asm_o !== 1'b0 || cnt !== 2'd0) begin
      errors++;
      $display("FAIL stall_handoff: got %b/%0d expected 0/0",
               asm_o, cnt);
    end
  endtask

  task automatic test_clear();
    logic [KS-1:0] k1, k2;
    kv = 1'b1; key = KS'($urandom);
    step();
    checks++;
    if (cnt !== 2'd1) begin
      errors++;
      $display("FAIL clear_pre: got %0d expected 1", cnt);
    end
    clr = 1'b1;
    step();
    clr = 1'b0; kv = 1'b0;
    checks++;
    if (cnt !== 2'd0 || asm_o !== 1'b0) begin
      errors++;
      $display("FAIL clear_cnt: got %0d/%b expected 0/0", cnt, asm_o);
    end
    k1 = KS'($urandom); k2 = KS'($urandom);
    kv = 1'b1; key = k1; step();
    key = k2; step();
    kv = 1'b0;
    checks++;
    if (word !== {k1, k2} || asm_o !== 1'b1) begin
      errors++;
      $display("FAIL clear_fresh: got %h expected %h", word, {k1, k2});
    end
  endtask

  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (word !== 8'h00 || asm_o !== 1'b0 || cnt !== 2'd0
        || rdy !== 1'b1) begin
      errors++;
      $display("FAIL async_rst: got %h/%b/%0d/%b expected 00/0/0/1",
               word, asm_o, cnt, rdy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [MS-1:0] exp;
    for (int i = 0; i < 400; i++) begin
      en   = ($urandom_range(0, 7) != 0);
      kv   = ($urandom_range(0, 2) != 0);
      mode = ($urandom_range(0, 3) == 0);
      ordy = ($urandom_range(0, 2) == 0);
      clr  = ($urandom_range(0, 40) == 0);
      key  = KS'($urandom);
      #1;
      checks++;
      if (rdy !== (!m_hold && en)) begin
        errors++;
        $display("FAIL rand_rdy %0d: got %b expected %b",
                 i, rdy, (!m_hold && en));
      end
      step();
      exp = m_word[MS-1:0];
      checks++;
      if (word !== exp || asm_o !== m_hold || cnt !== 2'(m_n)) begin
        errors++;
        $display("FAIL rand_out %0d: got %h/%b/%0d expected %h/%b/%0d",
                 i, word, asm_o, cnt, exp, m_hold, m_n);
      end
    end
    clr = 1'b0; kv = 1'b0; ordy = 1'b0; mode = 1'b0; en = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_shift_basic();
    test_backpressure();
    test_repeat();
    test_odd_size();
    test_stalls();
    test_clear();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
